uart_cmd_queue: RTL

UART_CMD_QUEUE -- requirements
Module: uart_cmd_queue

---
 rtl/uart_cmd_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/uart_cmd_queue.sv
// Command queue fed by the UART receiver: one byte per rx_valid rising edge,
// keeps only the U/D/L/R command bytes and presents the oldest one to the CPU.
module uart_cmd_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     pop,
  input  logic                     clr_ovf,
  output logic [31:0]              cmd_data,
  output logic                     cmd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [3:0]               leds
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          prev_valid_q, prev_valid_d;
  logic          overflow_q, overflow_d;
  logic [3:0]    leds_q, leds_d;

  logic          byte_ev, legal, full, do_push, do_pop, drop;
  logic [3:0]    cmd_code;

  always_comb begin
    cmd_code = 4'b0000;
    case (rx_data)
      8'h55:   cmd_code = 4'b0001;
      8'h44:   cmd_code = 4'b0010;
      8'h4C:   cmd_code = 4'b0100;
      8'h52:   cmd_code = 4'b1000;
      default: cmd_code = 4'b0000;
    endcase
  end

  always_comb begin
    byte_ev = rx_valid & ~prev_valid_q;
    legal   = byte_ev & (cmd_code != 4'b0000);
    full    = (count_q == FULL_CNT);
    do_pop  = pop & (count_q != '0);
    // A pop frees the slot on the same edge, so a full queue can still accept.
    do_push = legal & (~full | pop);
    drop    = legal & full & ~pop;

    prev_valid_d = rx_valid;
    head_d       = do_pop  ? head_q + 1'b1 : head_q;
    tail_d       = do_push ? tail_q + 1'b1 : tail_q;
    leds_d       = do_push ? cmd_code : leds_q;

    count_d = count_q;
    if (do_push && !do_pop)
      count_d = count_q + 1'b1;
    else if (do_pop && !do_push)
      count_d = count_q - 1'b1;

    overflow_d = overflow_q;
    if (clr_ovf)
      overflow_d = 1'b0;
    if (drop)
      overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      prev_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      leds_q       <= 4'b0000;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      prev_valid_q <= prev_valid_d;
      overflow_q   <= overflow_d;
      leds_q       <= leds_d;
    end
  end

  // Storage is deliberately unreset; it is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[tail_q] <= rx_data;
  end

  assign cmd_valid = (count_q != '0);
  assign cmd_data  = cmd_valid ? {24'h0, mem_q[head_q]} : 32'h0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign leds      = leds_q;

endmodule
